// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: takes parallel operands, adds one bit pair per clock LSB first
// through a registered carry, and returns the parallel sum and carry-out over valid/ready.
module serial_add_seq #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSr_q, aSr_d;
    logic [WIDTH-1:0] bSr_q, bSr_d;
    logic [WIDTH-1:0] resSr_q, resSr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sBit, cNext;

    // The full-adder cell fed by the low bits of the operand shift registers.
    assign {cNext, sBit} = 2'(aSr_q[0]) + 2'(bSr_q[0]) + 2'(carry_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            aSr_q   <= '0;
            bSr_q   <= '0;
            resSr_q <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            aSr_q   <= aSr_d;
            bSr_q   <= bSr_d;
            resSr_q <= resSr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        aSr_d   = aSr_q;
        bSr_d   = bSr_q;
        resSr_d = resSr_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    aSr_d   = a;
                    bSr_d   = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                aSr_d   = {1'b0, aSr_q[WIDTH-1:1]};
                bSr_d   = {1'b0, bSr_q[WIDTH-1:1]};
                resSr_d = {sBit, resSr_q[WIDTH-1:1]};
                carry_d = cNext;
                cnt_d   = cnt_q + CW'(1);
                // Last step: the result register is complete once this sum bit lands in the MSB.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = resSr_d;
                    co_d    = cNext;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign co        = co_q;

endmodule
